// File: rtl/clock_set_ctrl_if.sv
// Handshake bundle between the clock set controller and
// the button logic / BCD counter datapath.
interface clock_set_ctrl_if;
  logic       mode;
  logic       inc;
  logic       clr;
  logic [7:0] sec_q;
  logic [7:0] min_q;
  logic       sec_cin;
  logic       min_cin;
  logic       hour_cin;
  logic       sec_load;
  logic       min_load;
  logic [7:0] load_data;
  logic [1:0] state;

  modport master (
    input  mode,
    input  inc,
    input  clr,
    input  sec_q,
    input  min_q,
    output sec_cin,
    output min_cin,
    output hour_cin,
    output sec_load,
    output min_load,
    output load_data,
    output state
  );

  modport slave (
    output mode,
    output inc,
    output clr,
    output sec_q,
    output min_q,
    input  sec_cin,
    input  min_cin,
    input  hour_cin,
    input  sec_load,
    input  min_load,
    input  load_data,
    input  state
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Seconds prescaler, carry generation and set-mode FSM for
// a cascaded pair of BCD mod-60 counters.
module clock_set_ctrl #(
  parameter int DIV = 50000000,
  parameter int PW  = 26
) (
  input logic              clk,
  input logic              reset,
  clock_set_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_SEC = 2'b10,
    BAD     = 2'b11
  } state_e;

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic          sec_cin_q, sec_cin_d;
  logic          min_cin_q, min_cin_d;
  logic          hour_cin_q, hour_cin_d;
  logic          sec_load_q, sec_load_d;
  logic          min_load_q, min_load_d;
  logic [7:0]    data_q, data_d;
  logic          busy;
  logic          sec_top;
  logic          min_top;

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v
  );
    logic [3:0] lo;
    logic [3:0] hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo >= 4'd9) begin
      lo = 4'd0;
      if (hi >= 4'd5) hi = 4'd0;
      else            hi = hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  // q is stale while a load is in flight
  assign busy    = sec_load_q | min_load_q;
  assign sec_top = (bus.sec_q == 8'h59);
  assign min_top = (bus.min_q == 8'h59);

  always_comb begin
    state_d    = state_q;
    pre_d      = '0;
    tick_d     = 1'b0;
    sec_cin_d  = 1'b0;
    min_cin_d  = 1'b0;
    hour_cin_d = 1'b0;
    sec_load_d = 1'b0;
    min_load_d = 1'b0;
    data_d     = data_q;
    if (bus.clr) begin
      sec_load_d = 1'b1;
      min_load_d = 1'b1;
      data_d     = 8'h00;
    end else if (bus.mode) begin
      unique case (state_q)
        RUN:     state_d = SET_MIN;
        SET_MIN: state_d = SET_SEC;
        SET_SEC: state_d = RUN;
        default: state_d = RUN;
      endcase
    end else if (state_q == RUN) begin
      tick_d     = (pre_q == LAST);
      pre_d      = tick_d ? '0 : pre_q + 1'b1;
      sec_cin_d  = tick_q;
      min_cin_d  = tick_q & sec_top;
      hour_cin_d = tick_q & sec_top & min_top;
    end else if (bus.inc && !busy) begin
      if (state_q == SET_MIN) begin
        min_load_d = 1'b1;
        data_d     = bcd_inc(bus.min_q);
      end else if (state_q == SET_SEC) begin
        sec_load_d = 1'b1;
        data_d     = bcd_inc(bus.sec_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pre_q      <= '0;
      tick_q     <= 1'b0;
      sec_cin_q  <= 1'b0;
      min_cin_q  <= 1'b0;
      hour_cin_q <= 1'b0;
      sec_load_q <= 1'b0;
      min_load_q <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      tick_q     <= tick_d;
      sec_cin_q  <= sec_cin_d;
      min_cin_q  <= min_cin_d;
      hour_cin_q <= hour_cin_d;
      sec_load_q <= sec_load_d;
      min_load_q <= min_load_d;
      data_q     <= data_d;
    end
  end

  assign bus.sec_cin   = sec_cin_q;
  assign bus.min_cin   = min_cin_q;
  assign bus.hour_cin  = hour_cin_q;
  assign bus.sec_load  = sec_load_q;
  assign bus.min_load  = min_load_q;
  assign bus.load_data = data_q;
  assign bus.state     = state_q;

endmodule
